// File: rtl/cmd_pkg.sv
`default_nettype none
// ============================================================================
// Package : cmd_pkg
// Brief   : Shared TRS-80 /CMD record constants and saver state encoding.
//           Optional name header states exist only with CMD_SAVER_NAME_EN.
// Revision: 1.0 - initial release
// ============================================================================
package cmd_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_XFER = 8'h02;
    localparam logic [7:0] CMD_NAME = 8'h05;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
`ifdef CMD_SAVER_NAME_EN
        NAME_T = 4'd1,
        NAME_L = 4'd2,
        NAME_C = 4'd3,
`endif
        LD_T   = 4'd4,
        LD_L   = 4'd5,
        LD_ALO = 4'd6,
        LD_AHI = 4'd7,
        RD     = 4'd8,
        RDW    = 4'd9,
        LD_D   = 4'd10,
        XF_T   = 4'd11,
        XF_L   = 4'd12,
        XF_LO  = 4'd13,
        XF_HI  = 4'd14,
        FIN    = 4'd15
    } state_t;

    // Length byte counts the two address bytes; 256 data bytes wraps to 0x02.
    function automatic logic [7:0] cmd_len_byte(input logic [8:0] n);
        logic [8:0] s;
        s = n + 9'd2;
        return s[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_saver.sv
`default_nettype none
// ============================================================================
// Module  : cmd_saver
// Brief   : Walks a CPU RAM range and streams a TRS-80 /CMD file (load records
//           plus a transfer record). Define CMD_SAVER_NAME_EN to prepend a
//           6-character name header record.
// Revision: 1.0 - initial release
// ============================================================================
module cmd_saver
    import cmd_pkg::*;
#(
    parameter int BLOCK_MAX = 256,
    parameter int RD_LAT    = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] start_addr,
    input  logic [15:0] end_addr,
    input  logic [15:0] exec_addr,
    input  logic [47:0] save_name,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [16:0] out_addr,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [16:0] C_BLK = 17'(BLOCK_MAX);
    localparam logic [1:0]  C_LAT = 2'(RD_LAT);

    state_t      r_state;
    state_t      w_state_next;
    logic [16:0] r_ptr;
    logic [16:0] r_end;
    logic [15:0] r_exec;
    logic [8:0]  r_remain;
    logic [7:0]  r_data;
    logic [16:0] r_oaddr;
    logic [1:0]  r_lat;
    logic        r_err;

    logic        w_xfer;
    logic [16:0] w_left;
    logic [8:0]  w_n;
    logic [16:0] w_ptr_inc;

`ifdef CMD_SAVER_NAME_EN
    logic [47:0] r_name;
    logic [2:0]  r_name_idx;
`else
    logic        w_unused_name;
    assign w_unused_name = ^save_name;
`endif

    // Pointer arithmetic is 17-bit so a range ending at 0xFFFF terminates.
    assign w_xfer    = out_valid & out_ready;
    assign w_left    = r_end - r_ptr + 17'd1;
    assign w_n       = (w_left > C_BLK) ? C_BLK[8:0] : w_left[8:0];
    assign w_ptr_inc = r_ptr + 17'd1;

    assign mem_addr = r_ptr[15:0];
    assign out_addr = r_oaddr;
    assign error    = r_err;
    assign busy     = (r_state != IDLE) && (r_state != FIN);
    assign done     = (r_state == FIN) && !abort;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        out_valid    = 1'b0;
        out_data     = 8'h00;
        mem_rd       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && (start_addr <= end_addr)) begin
`ifdef CMD_SAVER_NAME_EN
                    w_state_next = NAME_T;
`else
                    w_state_next = LD_T;
`endif
                end
            end
`ifdef CMD_SAVER_NAME_EN
            NAME_T: begin
                out_valid = 1'b1;
                out_data  = CMD_NAME;
                if (w_xfer) w_state_next = NAME_L;
            end
            NAME_L: begin
                out_valid = 1'b1;
                out_data  = 8'h06;
                if (w_xfer) w_state_next = NAME_C;
            end
            NAME_C: begin
                out_valid = 1'b1;
                out_data  = r_name[47:40];
                if (w_xfer && (r_name_idx == 3'd5)) w_state_next = LD_T;
            end
`endif
            LD_T: begin
                out_valid = 1'b1;
                out_data  = CMD_LOAD;
                if (w_xfer) w_state_next = LD_L;
            end
            LD_L: begin
                out_valid = 1'b1;
                out_data  = cmd_len_byte(r_remain);
                if (w_xfer) w_state_next = LD_ALO;
            end
            LD_ALO: begin
                out_valid = 1'b1;
                out_data  = r_ptr[7:0];
                if (w_xfer) w_state_next = LD_AHI;
            end
            LD_AHI: begin
                out_valid = 1'b1;
                out_data  = r_ptr[15:8];
                if (w_xfer) w_state_next = RD;
            end
            RD: begin
                mem_rd       = 1'b1;
                w_state_next = RDW;
            end
            RDW: begin
                if (r_lat == C_LAT) w_state_next = LD_D;
            end
            LD_D: begin
                out_valid = 1'b1;
                out_data  = r_data;
                if (w_xfer) begin
                    if (r_remain == 9'd1) begin
                        w_state_next = (w_ptr_inc <= r_end) ? LD_T : XF_T;
                    end else begin
                        w_state_next = RD;
                    end
                end
            end
            XF_T: begin
                out_valid = 1'b1;
                out_data  = CMD_XFER;
                if (w_xfer) w_state_next = XF_L;
            end
            XF_L: begin
                out_valid = 1'b1;
                out_data  = 8'h02;
                if (w_xfer) w_state_next = XF_LO;
            end
            XF_LO: begin
                out_valid = 1'b1;
                out_data  = r_exec[7:0];
                if (w_xfer) w_state_next = XF_HI;
            end
            XF_HI: begin
                out_valid = 1'b1;
                out_data  = r_exec[15:8];
                if (w_xfer) w_state_next = FIN;
            end
            FIN: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (abort && (r_state != IDLE)) begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr      <= 17'd0;
            r_end      <= 17'd0;
            r_exec     <= 16'd0;
            r_remain   <= 9'd0;
            r_data     <= 8'h00;
            r_oaddr    <= 17'd0;
            r_lat      <= 2'd0;
            r_err      <= 1'b0;
`ifdef CMD_SAVER_NAME_EN
            r_name     <= 48'd0;
            r_name_idx <= 3'd0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (start_addr > end_addr) begin
                            r_err <= 1'b1;
                        end else begin
                            r_err      <= 1'b0;
                            r_ptr      <= {1'b0, start_addr};
                            r_end      <= {1'b0, end_addr};
                            r_exec     <= exec_addr;
                            r_oaddr    <= 17'd0;
`ifdef CMD_SAVER_NAME_EN
                            r_name     <= save_name;
                            r_name_idx <= 3'd0;
`endif
                        end
                    end
                end
`ifdef CMD_SAVER_NAME_EN
                NAME_C: begin
                    if (w_xfer) begin
                        r_name     <= {r_name[39:0], 8'h00};
                        r_name_idx <= r_name_idx + 3'd1;
                    end
                end
`endif
                LD_T: begin
                    if (w_xfer) r_remain <= w_n;
                end
                RD: begin
                    r_lat <= 2'd1;
                end
                RDW: begin
                    if (r_lat == C_LAT) begin
                        r_data <= mem_data;
                    end else begin
                        r_lat <= r_lat + 2'd1;
                    end
                end
                LD_D: begin
                    if (w_xfer) begin
                        r_ptr    <= w_ptr_inc;
                        r_remain <= r_remain - 9'd1;
                    end
                end
                default: begin
                end
            endcase
            if (w_xfer) begin
                r_oaddr <= r_oaddr + 17'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/cmd_saver.md
Name: cmd_saver

Overview:
- Inverse of the CMD program loader: walks a CPU RAM range and emits a TRS-80 /CMD file byte stream for upload to the HPS.
- Output is type-0x01 load records followed by one type-0x02 transfer record.
- Sits beside the loader in the top level, on clk_sys. It reads the 64K CPU RAM through a spare synchronous port and drives the ioctl upload data path.

Parameters:
- BLOCK_MAX, 256: maximum data bytes per load record; legal range 1..256.
- RD_LAT, 1: fixed RAM read latency in clocks; legal range 1..2.

Ports:
- clock  in  1  system clock (clk_sys, 42 MHz)
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin save; ignored unless idle
- abort  in  1  level: stop at the next byte boundary, return to idle
- start_addr  in  16  first RAM address to save
- end_addr  in  16  last RAM address, inclusive
- exec_addr  in  16  transfer (entry) address
- save_name  in  48  6 ASCII chars, used only with the optional feature
- mem_addr  out  16  RAM read address
- mem_rd  out  1  RAM read strobe
- mem_data  in  8  RAM read data, valid RD_LAT clocks after mem_rd
- out_valid  out  1  out_data is valid
- out_ready  in  1  sink accepts a byte (driven from ~ioctl_wait)
- out_data  out  8  file byte
- out_addr  out  17  file offset of out_data
- busy  out  1  save in progress
- done  out  1  one-cycle pulse after the last byte is accepted
- error  out  1  sticky; set on start with start_addr>end_addr; cleared by the next accepted start

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Internal counters 0.
- Start handling:
  - start is accepted only in IDLE.
  - The addresses are latched on the accepting cycle.
  - If start_addr>end_addr: set error, stay IDLE, emit nothing.
  - Otherwise: clear error, set busy, set out_addr=0.
- Handshake:
  - A byte transfers on a cycle with out_valid & out_ready.
  - out_data and out_addr hold stable while out_valid=1 and out_ready=0.
  - out_addr increments by 1 on each transfer.
  - out_valid never drops without a transfer, except on reset or abort.
- States: IDLE, [NAME_T, NAME_L, NAME_C], LD_T, LD_L, LD_ALO, LD_AHI, RD, RDW, LD_D, XF_T, XF_L, XF_LO, XF_HI, FIN.
- Load record, current pointer p:
  - n = min(BLOCK_MAX, end-p+1), computed in 17 bits.
  - Emitted bytes: 0x01, (n+2) mod 256, p[7:0], p[15:8], then n data bytes.
  - For n=256 the length byte is 0x02.
  - For n=254 the length byte is 0x00, matching the loader's 256-meaning convention.
- Data fetch:
  - RD: pulse mem_rd for one clock with mem_addr=p.
  - RDW: wait RD_LAT clocks, latch mem_data.
  - LD_D: present the latched byte. On transfer: p+=1, remaining-=1.
  - Then go to RD if the record has bytes left. Otherwise go to LD_T if p_17<=end, else to XF_T.
- Pointer width: p is held in 17 bits, so end_addr=0xFFFF terminates and never wraps to 0x0000.
- Transfer record: 0x02, 0x02, exec[7:0], exec[15:8].
- FIN: pulse done for one clock, clear busy, go to IDLE.
- Total length = 4*ceil(L/BLOCK_MAX) + L + 4, where L = end-start+1. Max 66564 bytes fits in 17 bits.
- Abort:
  - Sampled every cycle.
  - Takes effect immediately: out_valid=0, busy=0, no done, IDLE.
- Simultaneous events: start together with reset → reset wins. Abort in IDLE → no effect.
- Reset mid-operation: immediate return to IDLE with all outputs cleared; any RAM read in flight is discarded.

Optional Feature:
- Macro: CMD_SAVER_NAME_EN.
- Defined:
  - Before the first load record, emit a header record: 0x05, 0x06, save_name[47:40] … save_name[7:0] (6 bytes, MSB char first).
  - Total length increases by 8.
- Undefined:
  - NAME_* states are absent; save_name is unused.
  - First byte is 0x01.

Decomposition:
- Package cmd_pkg holds:
  - state enum;
  - record type constants CMD_LOAD=8'h01, CMD_XFER=8'h02, CMD_NAME=8'h05;
  - function cmd_len_byte(n) returning (n+2) mod 256.
- The loader should import the same constants.
- No sub-module: a single FSM with a datapath.
- The RD/RDW latency counter stays inline.

Test Plan:
- Single block: start=0x5200, end=0x5202, exec=0x5200, RAM AA BB CC, out_ready=1 → stream 01 05 00 52 AA BB CC 02 02 00 52; done once; final out_addr=10.
- Block split: start=0x6000, end=0x60FF+1 (257 bytes) → record 1 is 01 02 00 60 + 256 bytes; record 2 is 01 03 00 61 + 1 byte; then the transfer record; total 269 bytes.
- Top of memory: start=0xFFFE, end=0xFFFF → one record 01 04 FE FF + 2 bytes, then transfer. mem_addr never reaches 0x0000.
- Backpressure: toggle out_ready pseudo-randomly → byte sequence identical to the unstalled run; out_data/out_addr stable during stalls; mem_rd count equals L.
- Error and abort: start with start=0x7000, end=0x6FFF → error=1, no out_valid. A valid start clears error. Asserting abort after 5 bytes → out_valid=0 next cycle, busy=0, no done. Restart → stream begins at out_addr=0.
- With CMD_SAVER_NAME_EN and save_name="GAME  " → stream begins 05 06 47 41 4D 45 20 20 01 …
